// File: rtl/msx_bus_initiator_if.sv
// rtl/msx_bus_initiator_if.sv - requester handshake and MSX cartridge-slot bus bundle
interface msx_bus_initiator_if;
    logic        req;
    logic [1:0]  cmd;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy;
    logic        ack;
    logic [7:0]  rdata;
    logic        timeout;
    logic [15:0] addr;
    logic [7:0]  cdout;
    logic        cdout_oe;
    logic [7:0]  cdin;
    logic        sltsl_n;
    logic        merq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        wait_n;

    modport master (
        input  req, cmd, req_addr, req_wdata, cdin, wait_n,
        output busy, ack, rdata, timeout, addr, cdout, cdout_oe,
        output sltsl_n, merq_n, iorq_n, rd_n, wr_n, m1_n
    );

    modport slave (
        output req, cmd, req_addr, req_wdata, cdin, wait_n,
        input  busy, ack, rdata, timeout, addr, cdout, cdout_oe,
        input  sltsl_n, merq_n, iorq_n, rd_n, wr_n, m1_n
    );
endinterface

// File: rtl/msx_bus_initiator.sv
// rtl/msx_bus_initiator.sv - issues T-state-timed Z80/MSX memory and I/O cycles for an internal requester
module msx_bus_initiator #(
    parameter int DIV      = 4,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    msx_bus_initiator_if.master bus
);
    localparam int H  = DIV / 2;
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PH_HM1  = PW'(H - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [7:0]    WAIT_LIM = 8'(MAX_WAIT);

    typedef enum logic [2:0] {IDLE, T1, T2, TWA, TW, T3, DONE} state_t;

    state_t        state;
    logic [PW-1:0] ph;
    logic [7:0]    wait_cnt;
    logic [1:0]    cmd_q;
    logic          is_io;
    logic          is_wr;
    logic          at_sample;

    assign is_io = cmd_q[1];
    assign is_wr = cmd_q[0];
    assign bus.m1_n = 1'b1;

    // Last phase of the T-state where the target's WAIT line decides the next state.
    assign at_sample = (ph == PH_LAST) &&
                       (((state == T2) && !is_io) || (state == TWA) || (state == TW));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ph          <= '0;
            wait_cnt    <= '0;
            cmd_q       <= '0;
            bus.addr    <= '0;
            bus.cdout   <= '0;
            bus.cdout_oe <= 1'b0;
            bus.sltsl_n <= 1'b1;
            bus.merq_n  <= 1'b1;
            bus.iorq_n  <= 1'b1;
            bus.rd_n    <= 1'b1;
            bus.wr_n    <= 1'b1;
            bus.busy    <= 1'b0;
            bus.ack     <= 1'b0;
            bus.rdata   <= 8'hFF;
            bus.timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ph <= '0;
                    if (bus.req && !bus.busy) begin
                        state       <= T1;
                        cmd_q       <= bus.cmd;
                        wait_cnt    <= '0;
                        bus.timeout <= 1'b0;
                        bus.busy    <= 1'b1;
                        bus.addr    <= bus.req_addr;
                        bus.cdout_oe <= bus.cmd[0];
                        if (bus.cmd[0]) begin
                            bus.cdout <= bus.req_wdata;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ph       <= '0;
                    bus.ack  <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    ph <= (ph == PH_LAST) ? '0 : ph + PH_ONE;
                    case (state)
                        T1: begin
                            if (ph == PH_HM1 && !is_io) begin
                                bus.sltsl_n <= 1'b0;
                                bus.merq_n  <= 1'b0;
                                bus.rd_n    <= is_wr;
                            end
                            if (ph == PH_LAST) begin
                                state <= T2;
                                if (is_io) begin
                                    bus.iorq_n <= 1'b0;
                                    bus.rd_n   <= is_wr;
                                    bus.wr_n   <= !is_wr;
                                end else if (is_wr) begin
                                    bus.wr_n <= 1'b0;
                                end
                            end
                        end
                        T2: begin
                            if (ph == PH_LAST && is_io) begin
                                state <= TWA;
                            end
                        end
                        T3: begin
                            if (ph == PH_HM1) begin
                                bus.sltsl_n <= 1'b1;
                                bus.merq_n  <= 1'b1;
                                bus.iorq_n  <= 1'b1;
                                bus.rd_n    <= 1'b1;
                                bus.wr_n    <= 1'b1;
                            end
                            if (ph == PH_LAST) begin
                                state        <= DONE;
                                bus.ack      <= 1'b1;
                                bus.cdout_oe <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                    if (at_sample) begin
                        if (bus.wait_n) begin
                            state <= T3;
                            if (!is_wr) begin
                                bus.rdata <= bus.cdin;
                            end
                        end else if (state == TW && wait_cnt == WAIT_LIM) begin
                            // WAIT still asserted after the limit: finish the cycle with dummy data.
                            state       <= T3;
                            bus.timeout <= 1'b1;
                            bus.rdata   <= 8'hFF;
                        end else begin
                            state    <= TW;
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_msx_bus_initiator.sv
// tb/tb_msx_bus_initiator.sv - self-checking bench for msx_bus_initiator
module tb_msx_bus_initiator;
    localparam int DIV  = 4;
    localparam int H    = DIV / 2;
    localparam int MAXW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    msx_bus_initiator_if bus ();

    msx_bus_initiator #(.DIV(DIV), .MAX_WAIT(MAXW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  cmd;
        logic [15:0] a;
        logic [7:0]  wd;
        logic [7:0]  din;
        int          nwait;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       tmo;
        logic       chk_rd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit   io = v.cmd[1];
        bit   wr = v.cmd[0];
        bit   tmo = (v.nwait > MAXW);
        int   w = tmo ? MAXW : v.nwait;
        int   first = io ? 3 * DIV : 2 * DIV;
        int   fs = first + DIV * w;
        int   last_low = tmo ? 100000 : ((v.nwait == 0) ? 0 : first + DIV * (v.nwait - 1));
        int   ack_c = (io ? 4 : 3) * DIV + 1 + DIV * w;
        int   send = ack_c - DIV + H - 1;
        int   werr = 0;
        int   berr = 0;
        int   first_bad = -1;
        bit   got_ack = 0;
        exp_t e;
        exp_t g;
        e.cyc = ack_c;
        e.rdata = tmo ? 8'hFF : v.din;
        e.tmo = tmo;
        e.chk_rd = !wr || tmo;
        sb.push_back(e);
        bus.req = 1'b1;
        bus.cmd = v.cmd;
        bus.req_addr = v.a;
        bus.req_wdata = v.wd;
        bus.wait_n = 1'b1;
        bus.cdin = ~v.din;
        @(posedge clk);
        for (int k = 1; k <= 80 && !got_ack; k++) begin
            logic [6:0] act_s;
            logic [6:0] exp_s;
            bit mem_lo;
            bit io_lo;
            @(negedge clk);
            bus.req = 1'b0;
            mem_lo = !io && k >= 1 + H && k <= send;
            io_lo  = io && k >= 1 + DIV && k <= send;
            exp_s = {!mem_lo, !mem_lo, !io_lo, !((mem_lo || io_lo) && !wr),
                     !((!io && wr && k >= 1 + DIV && k <= send) || (io_lo && wr)),
                     1'b1, wr && k <= ack_c - 1};
            act_s = {bus.sltsl_n, bus.merq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.m1_n, bus.cdout_oe};
            if (act_s !== exp_s) begin
                werr++;
                if (first_bad < 0) first_bad = k;
            end
            if (bus.busy !== 1'b1 || bus.addr !== v.a) berr++;
            if (k == 1 && wr) check({v.name, ".cdout"}, 32'(bus.cdout), 32'(v.wd));
            if (bus.ack === 1'b1) begin
                got_ack = 1;
                if (sb.size() == 0) begin
                    check({v.name, ".unexpected_ack"}, 32'd1, 32'd0);
                end else begin
                    g = sb.pop_front();
                    check({v.name, ".ack_cycle"}, 32'(k), 32'(g.cyc));
                    check({v.name, ".timeout"}, 32'(bus.timeout), 32'(g.tmo));
                    if (g.chk_rd) check({v.name, ".rdata"}, 32'(bus.rdata), 32'(g.rdata));
                end
            end
            bus.wait_n = !(k <= last_low);
            bus.cdin = (k == fs) ? v.din : ~v.din;
        end
        if (!got_ack) begin
            check({v.name, ".ack_seen"}, 32'd0, 32'd1);
            sb.delete();
        end
        if (werr != 0) $display("  %s first strobe error at cycle %0d", v.name, first_bad);
        check({v.name, ".strobe_errs"}, 32'(werr), 32'd0);
        check({v.name, ".busy_addr_errs"}, 32'(berr), 32'd0);
        @(negedge clk);
        bus.wait_n = 1'b1;
        check({v.name, ".post_busy_ack"}, {30'd0, bus.busy, bus.ack}, 32'd0);
        if (e.chk_rd) check({v.name, ".rdata_held"}, 32'(bus.rdata), 32'(e.rdata));
    endtask

    initial begin
        int acks;
        int bad;
        vecs[0] = '{"mem_rd",     2'b00, 16'h6000, 8'h00, 8'h5A, 0};
        vecs[1] = '{"mem_wr",     2'b01, 16'h9000, 8'h3F, 8'h00, 0};
        vecs[2] = '{"io_wr",      2'b11, 16'h008E, 8'hC3, 8'h00, 0};
        vecs[3] = '{"io_rd",      2'b10, 16'h0098, 8'h00, 8'hA5, 0};
        vecs[4] = '{"mem_rd_w2",  2'b00, 16'h4000, 8'h00, 8'h81, 2};
        vecs[5] = '{"mem_rd_tmo", 2'b00, 16'h7FFF, 8'h00, 8'h00, 9};
        vecs[6] = '{"io_rd_w1",   2'b10, 16'h00A8, 8'h00, 8'h3C, 1};
        vecs[7] = '{"mem_wr_w3",  2'b01, 16'hBFFE, 8'h55, 8'h00, 3};
        vecs[8] = '{"io_wr_tmo",  2'b11, 16'h00FF, 8'hAA, 8'h00, 9};

        bus.req = 1'b0;
        bus.cmd = 2'b00;
        bus.req_addr = 16'h0;
        bus.req_wdata = 8'h0;
        bus.cdin = 8'h00;
        bus.wait_n = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.strobes", 32'({bus.sltsl_n, bus.merq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.m1_n}), 32'h3F);
        check("reset.flags", 32'({bus.busy, bus.ack, bus.timeout, bus.cdout_oe}), 32'h0);
        check("reset.rdata", 32'(bus.rdata), 32'hFF);
        check("reset.addr_cdout", {bus.addr, bus.cdout, 8'h00}, 32'h0);

        // req coincident with reset is dropped
        bus.req = 1'b1;
        bus.req_addr = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.req = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.merq_n !== 1'b1 || bus.addr === 16'h2222) bad++;
        end
        check("req_with_reset.idle_errs", 32'(bad), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // second req while busy must be ignored
        bus.req = 1'b1;
        bus.cmd = 2'b00;
        bus.req_addr = 16'h6000;
        bus.cdin = 8'h5A;
        bus.wait_n = 1'b1;
        @(posedge clk);
        acks = 0;
        bad = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bus.req = (k == 5);
            if (k == 5) begin
                bus.cmd = 2'b11;
                bus.req_addr = 16'h1234;
            end
            if (bus.ack === 1'b1) begin
                acks++;
                check("busy_req.ack_cycle", 32'(k), 32'd13);
                check("busy_req.rdata", 32'(bus.rdata), 32'h5A);
            end
            if (bus.addr === 16'h1234 || bus.iorq_n !== 1'b1) bad++;
        end
        check("busy_req.ack_count", 32'(acks), 32'd1);
        check("busy_req.second_cycle", 32'(bad), 32'd0);

        // reset in the middle of a memory write
        bus.req = 1'b1;
        bus.cmd = 2'b01;
        bus.req_addr = 16'h9000;
        bus.req_wdata = 8'h3F;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
        check("rst_abort.pre_merq", 32'(bus.merq_n), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_abort.strobes", 32'({bus.sltsl_n, bus.merq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.cdout_oe}), 32'h3E);
        check("rst_abort.busy_addr", {15'd0, bus.busy, bus.addr}, 32'h0);
        acks = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.ack === 1'b1) acks++;
        end
        check("rst_abort.no_ack", 32'(acks), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
